// File: rtl/id_ctrl.sv
// rtl/id_ctrl.sv - decode-stage controller: ID register, load-use stall, BEQ resolve, HALT
module id_ctrl #(
   parameter logic [15:0] NOP_INSTR  = 16'h0000,
   parameter int unsigned LOAD_STALL = 1,
   parameter logic [3:0]  OP_LOAD    = 4'h8,
   parameter logic [3:0]  OP_STORE   = 4'h9,
   parameter logic [3:0]  OP_BEQ     = 4'hC,
   parameter logic [3:0]  OP_HALT    = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instruction,
   input  logic [15:0] pc,
   input  logic [15:0] rs_data,
   input  logic [15:0] rt_data,
   output logic        if_enable,
   output logic        branch_enable,
   output logic [5:0]  imm_pc_offset,
   output logic [2:0]  rs_addr,
   output logic [2:0]  rt_addr,
   output logic        ex_valid,
   output logic [15:0] ex_instr,
   output logic [15:0] ex_pc,
   output logic [2:0]  ex_rd,
   output logic        ex_we,
   output logic        ex_is_load,
   output logic        halted
);

   typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_HALT} state_t;

   localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] id_instr_q, id_pc_q;
   logic [15:0] ex_instr_q, ex_pc_q;
   logic        ex_valid_q, ex_we_q, ex_is_load_q;

   logic [3:0]  id_op;
   logic        id_is_nop, reads_rs, reads_rt, hazard, id_we, id_is_load;
   logic        if_en, br_en, id_load, id_squash, ex_adv;

   assign id_op      = id_instr_q[15:12];
   assign id_is_nop  = (id_instr_q == NOP_INSTR);
   assign reads_rs   = !id_is_nop && (id_op != OP_HALT);
   assign reads_rt   = !id_is_nop && ((id_op <= 4'h7) || (id_op == OP_STORE) || (id_op == OP_BEQ));
   assign id_we      = !id_is_nop && (id_op <= 4'h8);
   assign id_is_load = !id_is_nop && (id_op == OP_LOAD);

   assign rs_addr = id_instr_q[8:6];
   assign rt_addr = id_instr_q[5:3];
   assign ex_rd   = ex_instr_q[11:9];

   assign hazard = ex_valid_q && ex_is_load_q &&
                   ((reads_rs && (ex_rd == rs_addr)) || (reads_rt && (ex_rd == rt_addr)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      if_en     = 1'b0;
      br_en     = 1'b0;
      id_load   = 1'b0;
      id_squash = 1'b0;
      ex_adv    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (hazard) begin
               // single-cycle stall stays in RUN; the bubble clears the hazard next cycle
               if (LOAD_STALL > 1) begin
                  state_d = ST_STALL;
                  cnt_d   = STALL_INIT;
               end
            end else if (!id_is_nop && (id_op == OP_HALT)) begin
               state_d   = ST_HALT;
               id_squash = 1'b1;
            end else if (!id_is_nop && (id_op == OP_BEQ)) begin
               if_en = 1'b1;
               br_en = (rs_data == rt_data);
               if (br_en) id_squash = 1'b1;
               else       id_load   = 1'b1;
            end else begin
               if_en   = 1'b1;
               id_load = 1'b1;
               ex_adv  = 1'b1;
            end
         end
         ST_STALL: begin
            if (cnt_q <= 3'd1) begin
               state_d = ST_RUN;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_HALT: ;
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RUN;
         cnt_q        <= 3'd0;
         id_instr_q   <= NOP_INSTR;
         id_pc_q      <= 16'd0;
         ex_valid_q   <= 1'b0;
         ex_instr_q   <= 16'd0;
         ex_pc_q      <= 16'd0;
         ex_we_q      <= 1'b0;
         ex_is_load_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (id_load) begin
            id_instr_q <= instruction;
            id_pc_q    <= pc;
         end else if (id_squash) begin
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= pc;
         end
         if (ex_adv) begin
            ex_valid_q   <= !id_is_nop;
            ex_instr_q   <= id_instr_q;
            ex_pc_q      <= id_pc_q;
            ex_we_q      <= id_we;
            ex_is_load_q <= id_is_load;
         end else begin
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= NOP_INSTR;
            ex_we_q      <= 1'b0;
            ex_is_load_q <= 1'b0;
         end
      end
   end

   // fetch-facing outputs are forced to their idle values while reset is held
   assign if_enable     = if_en | ~rst;
   assign branch_enable = br_en & rst;
   assign imm_pc_offset = rst ? id_instr_q[5:0] : 6'd0;

   assign ex_valid   = ex_valid_q;
   assign ex_instr   = ex_instr_q;
   assign ex_pc      = ex_pc_q;
   assign ex_we      = ex_we_q;
   assign ex_is_load = ex_is_load_q;
   assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_id_ctrl.sv
// tb/tb_id_ctrl.sv - directed bench for id_ctrl with a small fetch-stage model
module tb_id_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] instruction, pc, rs_data, rt_data;
   logic [15:0] imem [0:31];
   logic [15:0] fpc;

   logic        if_enable, branch_enable, ex_valid, ex_we, ex_is_load, halted;
   logic [5:0]  imm_pc_offset;
   logic [2:0]  rs_addr, rt_addr, ex_rd;
   logic [15:0] ex_instr, ex_pc;

   logic        s_if_enable, s_branch_enable, s_ex_valid, s_ex_we, s_ex_is_load, s_halted;
   logic [5:0]  s_imm;
   logic [2:0]  s_rs_addr, s_rt_addr, s_ex_rd;
   logic [15:0] s_ex_instr, s_ex_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign instruction = imem[fpc[4:0]];
   assign pc          = fpc;

   // fetch stage: offset is added to the already-advanced fetch pc
   always @(posedge clk or negedge rst) begin
      if (!rst)               fpc <= 16'd0;
      else if (branch_enable) fpc <= fpc + {10'd0, imm_pc_offset};
      else if (if_enable)     fpc <= fpc + 16'd1;
   end

   id_ctrl dut (
      .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
      .rs_data(rs_data), .rt_data(rt_data),
      .if_enable(if_enable), .branch_enable(branch_enable), .imm_pc_offset(imm_pc_offset),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .ex_valid(ex_valid), .ex_instr(ex_instr),
      .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .halted(halted)
   );

   id_ctrl #(.LOAD_STALL(3)) dut_s3 (
      .clk(clk), .rst(rst), .instruction(instruction), .pc(pc),
      .rs_data(rs_data), .rt_data(rt_data),
      .if_enable(s_if_enable), .branch_enable(s_branch_enable), .imm_pc_offset(s_imm),
      .rs_addr(s_rs_addr), .rt_addr(s_rt_addr), .ex_valid(s_ex_valid), .ex_instr(s_ex_instr),
      .ex_pc(s_ex_pc), .ex_rd(s_ex_rd), .ex_we(s_ex_we), .ex_is_load(s_ex_is_load),
      .halted(s_halted)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step(2);
      rst = 1'b1;
   endtask

   initial begin
      // reset with random inputs
      for (int i = 0; i < 32; i++) imem[i] = 16'($urandom);
      rs_data = 16'($urandom);
      rt_data = 16'($urandom);
      step(3);
      check("rst_ex_valid", ex_valid, 0);
      check("rst_if_enable", if_enable, 1);
      check("rst_branch", branch_enable, 0);
      check("rst_halted", halted, 0);
      check("rst_imm", imm_pc_offset, 0);
      check("rst_ex_instr", ex_instr, 0);

      // straight-line ALU
      clear_imem();
      imem[0] = 16'h1298;
      rst = 1'b1;
      step(1);
      check("alu_rs_addr", rs_addr, 2);
      check("alu_rt_addr", rt_addr, 3);
      step(1);
      check("alu_ex_instr", ex_instr, 16'h1298);
      check("alu_ex_rd", ex_rd, 1);
      check("alu_ex_we", ex_we, 1);
      check("alu_ex_pc", ex_pc, 0);
      check("alu_ex_valid", ex_valid, 1);

      // load-use: LOAD rd=3, then ALU reading rs=3
      clear_imem();
      imem[0] = 16'h8600;
      imem[1] = 16'h14C0;
      do_reset();
      step(2);
      check("lu_if_enable", if_enable, 0);
      check("lu_ex_is_load", ex_is_load, 1);
      check("lu_ex_rd", ex_rd, 3);
      check("lu_ex_we", ex_we, 1);
      check("s3_if_enable_0", s_if_enable, 0);
      step(1);
      check("lu_bubble", ex_valid, 0);
      check("lu_if_resume", if_enable, 1);
      check("lu_fetch_held", fpc, 2);
      check("s3_if_enable_1", s_if_enable, 0);
      check("s3_bubble_1", s_ex_valid, 0);
      step(1);
      check("lu_alu_ex", ex_instr, 16'h14C0);
      check("lu_alu_pc", ex_pc, 1);
      check("lu_alu_valid", ex_valid, 1);
      check("s3_if_enable_2", s_if_enable, 0);
      check("s3_bubble_2", s_ex_valid, 0);
      step(1);
      check("s3_if_resume", s_if_enable, 1);
      check("s3_bubble_3", s_ex_valid, 0);
      step(1);
      check("s3_alu_ex", s_ex_instr, 16'h14C0);
      check("s3_alu_valid", s_ex_valid, 1);
      check("s3_alu_pc", s_ex_pc, 1);

      // BEQ taken at pc 10, imm 4
      clear_imem();
      imem[10] = 16'hC044;
      imem[11] = 16'h1298;
      imem[12] = 16'h3000;
      imem[15] = 16'h2A00;
      rs_data = 16'h0005;
      rt_data = 16'h0005;
      do_reset();
      step(11);
      check("beq_t_branch", branch_enable, 1);
      check("beq_t_imm", imm_pc_offset, 4);
      check("beq_t_rs_addr", rs_addr, 1);
      check("beq_t_if_enable", if_enable, 1);
      step(1);
      check("beq_t_branch_off", branch_enable, 0);
      check("beq_t_fetch_pc", fpc, 15);
      check("beq_t_id_nop", imm_pc_offset, 0);
      check("beq_t_ex_bubble", ex_valid, 0);
      step(1);
      check("beq_t_squash", ex_valid, 0);
      step(1);
      check("beq_t_target_ex", ex_instr, 16'h2A00);
      check("beq_t_target_pc", ex_pc, 15);

      // BEQ not taken
      rt_data = 16'h0006;
      do_reset();
      step(11);
      check("beq_n_branch", branch_enable, 0);
      check("beq_n_if_enable", if_enable, 1);
      step(1);
      check("beq_n_fetch_pc", fpc, 12);
      step(1);
      check("beq_n_ex_instr", ex_instr, 16'h1298);
      check("beq_n_ex_pc", ex_pc, 11);

      // HALT at pc 7
      clear_imem();
      imem[7] = 16'hF000;
      do_reset();
      step(8);
      check("halt_if_enable", if_enable, 0);
      check("halt_not_yet", halted, 0);
      for (int i = 0; i < 20; i++) begin
         step(1);
         check("halt_halted", halted, 1);
         check("halt_if_off", if_enable, 0);
         check("halt_ex_valid", ex_valid, 0);
         check("halt_fetch_pc", fpc, 8);
      end
      rst = 1'b0;
      #1;
      check("halt_rst_clear", halted, 0);
      check("halt_rst_if", if_enable, 1);

      // async reset while LOAD_STALL=3 instance sits in STALL
      clear_imem();
      imem[0] = 16'h8600;
      imem[1] = 16'h14C0;
      do_reset();
      step(3);
      check("ar_in_stall", s_if_enable, 0);
      #2;
      rst = 1'b0;
      #1;
      check("ar_if_enable", s_if_enable, 1);
      check("ar_branch", s_branch_enable, 0);
      check("ar_imm", s_imm, 0);
      check("ar_ex_valid", s_ex_valid, 0);
      check("ar_ex_instr", s_ex_instr, 0);
      check("ar_ex_is_load", s_ex_is_load, 0);
      check("ar_ex_we", s_ex_we, 0);
      check("ar_rs_addr", s_rs_addr, 0);
      check("ar_halted", s_halted, 0);
      check("ar_main_if", if_enable, 1);
      step(1);
      check("ar_hold_if", s_if_enable, 1);
      rst = 1'b1;
      step(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
